// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole round controller.
// Holds the controller state encoding, the mole count and the
// random-word to mole-index mapping.
package mole_pkg;

   localparam int N_MOLES = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PICK = 2'd1,
      UP   = 2'd2,
      GAP  = 2'd3
   } mole_state_e;

   // Fold a 4-bit random nibble onto 0..9 (10..15 wrap to 0..5).
   function automatic logic [3:0] idx_from_rnd(input logic [3:0] r);
      return (r >= 4'd10) ? 4'(r - 4'd10) : r;
   endfunction

endpackage

// File: rtl/mole_timer.sv
// Loadable down-counter shared by the UP and GAP phases.
// Loading N-1 makes expired rise after exactly N cycles in the phase.
module mole_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/mole_ctrl.sv
// Game-round controller: draws a mole index from prbs16, lights it for a
// bounded window, scores edge-detected button hits, runs ROUNDS moles.
// Optional feature macro: MOLE_NOREPEAT_EN (never light the same mole twice
// in a row).
// Handshake: start is a single-cycle request honoured only while busy=0;
// shift_en, hit, miss and done are single-cycle pulses with no back-pressure.
module mole_ctrl
   import mole_pkg::*;
#(
   parameter int UP_CYCLES  = 50_000_000,
   parameter int GAP_CYCLES = 25_000_000,
   parameter int ROUNDS     = 20,
   parameter int SCORE_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [9:0]         rnd,
   input  logic [9:0]         btn,
   output logic               shift_en,
   output logic [9:0]         mole,
   output logic               hit,
   output logic               miss,
   output logic               done,
   output logic               busy,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         dbg_state
);

   localparam int TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int RW   = $clog2(ROUNDS + 1);
   localparam logic [TW-1:0] UP_LOAD  = TW'(UP_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
   localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

   mole_state_e     state, state_n;
   logic [9:0]      btn_q, press, mole_vec;
   logic [3:0]      idx_q, idx_n;
   logic [RW-1:0]   rnd_cnt;
   logic            tmr_load, tmr_exp;
   logic [TW-1:0]   tmr_val;
   logic            hit_n, miss_n, done_n;
   logic            game_clr, score_inc, rnd_inc;
   logic            unused_rnd;

   // Only the low nibble of the random word selects the mole.
   assign unused_rnd = ^rnd[9:4];

   assign press    = btn & ~btn_q;
   assign mole_vec = {{(N_MOLES-1){1'b0}}, 1'b1} << idx_q;

   mole_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

`ifdef MOLE_NOREPEAT_EN
   logic [3:0] last_idx;

   // Remember the previous mole so the next draw can be bumped past it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_idx <= '0;
      end else if (state == PICK) begin
         last_idx <= idx_n;
      end
   end

   // Map the random nibble, stepping to the next mole on a repeat.
   always_comb begin
      idx_n = idx_from_rnd(rnd[3:0]);
      if (idx_n == last_idx) begin
         idx_n = (idx_n == 4'd9) ? 4'd0 : 4'(idx_n + 4'd1);
      end
   end
`else
   // Map the random nibble; repeats are allowed.
   always_comb begin
      idx_n = idx_from_rnd(rnd[3:0]);
   end
`endif

   // Next-state, timer load and pulse decisions.
   always_comb begin
      state_n   = state;
      tmr_load  = 1'b0;
      tmr_val   = UP_LOAD;
      hit_n     = 1'b0;
      miss_n    = 1'b0;
      done_n    = 1'b0;
      game_clr  = 1'b0;
      score_inc = 1'b0;
      rnd_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               game_clr = 1'b1;
               state_n  = PICK;
            end
         end
         PICK: begin
            tmr_load = 1'b1;
            tmr_val  = UP_LOAD;
            state_n  = UP;
         end
         UP: begin
            // A hit in the timeout cycle still counts as a hit.
            if (|(press & mole_vec)) begin
               hit_n     = 1'b1;
               score_inc = 1'b1;
               tmr_load  = 1'b1;
               tmr_val   = GAP_LOAD;
               state_n   = GAP;
            end else if (tmr_exp) begin
               miss_n   = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = GAP_LOAD;
               state_n  = GAP;
            end
         end
         GAP: begin
            if (tmr_exp) begin
               rnd_inc = 1'b1;
               if (rnd_cnt == LAST_RND) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = PICK;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register and registered event pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         hit   <= 1'b0;
         miss  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         hit   <= hit_n;
         miss  <= miss_n;
         done  <= done_n;
      end
   end

   // Button history for rising-edge press detection.
   always_ff @(posedge clk) begin
      if (!rst) begin
         btn_q <= '0;
      end else begin
         btn_q <= btn;
      end
   end

   // Capture the mole index while prbs16 is being advanced.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q <= '0;
      end else if (state == PICK) begin
         idx_q <= idx_n;
      end
   end

   // Saturating score and round counter, both cleared at game start.
   always_ff @(posedge clk) begin
      if (!rst) begin
         score   <= '0;
         rnd_cnt <= '0;
      end else begin
         if (game_clr) begin
            score   <= '0;
            rnd_cnt <= '0;
         end else begin
            if (score_inc && (score != '1)) begin
               score <= score + SCORE_W'(1);
            end
            if (rnd_inc) begin
               rnd_cnt <= rnd_cnt + RW'(1);
            end
         end
      end
   end

   assign shift_en  = (state == PICK);
   assign busy      = (state != IDLE);
   assign mole      = (state == UP) ? mole_vec : '0;
   assign dbg_state = state;

endmodule

// File: tb/tb_mole_ctrl.sv
// Directed bench for mole_ctrl with UP_CYCLES=4, GAP_CYCLES=2, ROUNDS=3.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_mole_ctrl;
   import mole_pkg::*;

   logic       clk;
   logic       rst;
   logic       start;
   logic [9:0] rnd;
   logic [9:0] btn;
   logic       shift_en;
   logic [9:0] mole;
   logic       hit;
   logic       miss;
   logic       done;
   logic       busy;
   logic [7:0] score;
   logic [1:0] dbg_state;

   int n_vec = 0;
   int n_err = 0;

   mole_ctrl #(
      .UP_CYCLES  (4),
      .GAP_CYCLES (2),
      .ROUNDS     (3),
      .SCORE_W    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rnd       (rnd),
      .btn       (btn),
      .shift_en  (shift_en),
      .mole      (mole),
      .hit       (hit),
      .miss      (miss),
      .done      (done),
      .busy      (busy),
      .score     (score),
      .dbg_state (dbg_state)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      start = 1'b0;
      btn   = '0;
      rnd   = '0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      start = 1'b1;
      btn   = '0;
      rnd   = 10'h00C;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if ({shift_en, hit, miss, done, busy} !== 5'b0) begin n_err++; $display("FAIL reset_pulses: got %b expected 00000", {shift_en, hit, miss, done, busy}); end
         n_vec++; if (mole !== 10'h000) begin n_err++; $display("FAIL reset_mole: got %h expected 000", mole); end
         n_vec++; if (score !== 8'h00) begin n_err++; $display("FAIL reset_score: got %h expected 00", score); end
         n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
      end
      start = 1'b0;
      rst   = 1'b1;
      tick();
   endtask

   task automatic test_miss();
      do_reset();
      rnd   = 10'h00C;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++; if (shift_en !== 1'b1) begin n_err++; $display("FAIL miss_shift: got %b expected 1", shift_en); end
      n_vec++; if (mole !== 10'h000) begin n_err++; $display("FAIL miss_pick_mole: got %h expected 000", mole); end
      tick();
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (mole !== 10'b0000000100) begin n_err++; $display("FAIL miss_up_mole[%0d]: got %h expected 004", i, mole); end
         n_vec++; if ({shift_en, miss, hit} !== 3'b000) begin n_err++; $display("FAIL miss_up_pulses[%0d]: got %b expected 000", i, {shift_en, miss, hit}); end
         tick();
      end
      n_vec++; if (miss !== 1'b1) begin n_err++; $display("FAIL miss_pulse: got %b expected 1", miss); end
      n_vec++; if (mole !== 10'h000) begin n_err++; $display("FAIL miss_gap_mole: got %h expected 000", mole); end
      n_vec++; if (score !== 8'd0) begin n_err++; $display("FAIL miss_score: got %0d expected 0", score); end
      tick();
      n_vec++; if ({miss, busy} !== 2'b01) begin n_err++; $display("FAIL miss_gap2: got %b expected 01", {miss, busy}); end
      tick();
      n_vec++; if (shift_en !== 1'b1) begin n_err++; $display("FAIL miss_next_pick: got %b expected 1", shift_en); end
   endtask

   task automatic test_hit();
      do_reset();
      rnd   = 10'h005;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n_vec++; if (mole !== 10'h020) begin n_err++; $display("FAIL hit_mole: got %h expected 020", mole); end
      tick();
      btn = 10'h020;
      tick();
      n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL hit_pulse: got %b expected 1", hit); end
      n_vec++; if (mole !== 10'h000) begin n_err++; $display("FAIL hit_mole_off: got %h expected 000", mole); end
      n_vec++; if (score !== 8'd1) begin n_err++; $display("FAIL hit_score: got %0d expected 1", score); end
      n_vec++; if (dbg_state !== GAP) begin n_err++; $display("FAIL hit_state: got %0d expected 3", dbg_state); end
      tick();
      n_vec++; if ({hit, shift_en, dbg_state} !== {2'b00, GAP}) begin n_err++; $display("FAIL hit_gap2: got %b expected 0011", {hit, shift_en, dbg_state}); end
      tick();
      n_vec++; if (shift_en !== 1'b1) begin n_err++; $display("FAIL hit_gap_len: got %b expected 1", shift_en); end
      btn = '0;
   endtask

   task automatic test_held_button();
      do_reset();
      btn   = 10'h020;
      rnd   = 10'h005;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (mole !== 10'h020) begin n_err++; $display("FAIL held_mole[%0d]: got %h expected 020", i, mole); end
         n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL held_hit[%0d]: got %b expected 0", i, hit); end
         btn = (i == 1) ? 10'h028 : 10'h020;
         tick();
      end
      n_vec++; if ({hit, miss} !== 2'b01) begin n_err++; $display("FAIL held_miss: got hit,miss=%b expected 01", {hit, miss}); end
      n_vec++; if (score !== 8'd0) begin n_err++; $display("FAIL held_score: got %0d expected 0", score); end
      btn = '0;
   endtask

   task automatic test_back_to_back();
      logic [9:0] rnd_tab [0:2];
      logic [9:0] exp_tab [0:2];
      rnd_tab = '{10'h001, 10'h3F3, 10'h00F};
      exp_tab = '{10'h002, 10'h008, 10'h020};
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int r = 0; r < 3; r++) begin
         n_vec++; if (shift_en !== 1'b1) begin n_err++; $display("FAIL game_pick[%0d]: got %b expected 1", r, shift_en); end
         rnd   = rnd_tab[r];
         start = (r == 1);
         tick();
         n_vec++; if (mole !== exp_tab[r]) begin n_err++; $display("FAIL game_mole[%0d]: got %h expected %h", r, mole, exp_tab[r]); end
         btn = exp_tab[r];
         tick();
         btn   = '0;
         start = 1'b0;
         n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL game_hit[%0d]: got %b expected 1", r, hit); end
         n_vec++; if (score !== 8'(r + 1)) begin n_err++; $display("FAIL game_score[%0d]: got %0d expected %0d", r, score, r + 1); end
         tick();
         tick();
      end
      n_vec++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL game_done: got done,busy=%b expected 10", {done, busy}); end
      n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL game_idle: got %0d expected 0", dbg_state); end
      n_vec++; if (score !== 8'd3) begin n_err++; $display("FAIL game_final_score: got %0d expected 3", score); end
      tick();
      n_vec++; if ({done, busy, shift_en} !== 3'b000) begin n_err++; $display("FAIL game_after_done: got %b expected 000", {done, busy, shift_en}); end
   endtask

   task automatic test_repeat();
      logic [9:0] rnd_tab [0:2];
      logic [9:0] exp_tab [0:2];
      logic [9:0] exp_g2;
      rnd_tab = '{10'h007, 10'h007, 10'h009};
`ifdef MOLE_NOREPEAT_EN
      exp_tab = '{10'h080, 10'h100, 10'h200};
      exp_g2  = 10'h001;
`else
      exp_tab = '{10'h080, 10'h080, 10'h200};
      exp_g2  = 10'h200;
`endif
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int r = 0; r < 3; r++) begin
         rnd = rnd_tab[r];
         tick();
         n_vec++; if (mole !== exp_tab[r]) begin n_err++; $display("FAIL repeat_mole[%0d]: got %h expected %h", r, mole, exp_tab[r]); end
         repeat (6) tick();
      end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL repeat_done: got %b expected 1", done); end
      start = 1'b1;
      tick();
      start = 1'b0;
      rnd   = 10'h009;
      tick();
      n_vec++; if (mole !== exp_g2) begin n_err++; $display("FAIL repeat_wrap: got %h expected %h", mole, exp_g2); end
   endtask

   task automatic test_reset_mid_up();
      do_reset();
      rnd   = 10'h005;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      btn = 10'h020;
      rst = 1'b0;
      tick();
      n_vec++; if ({hit, miss, done, busy} !== 4'b0) begin n_err++; $display("FAIL midup_pulses: got %b expected 0000", {hit, miss, done, busy}); end
      n_vec++; if (mole !== 10'h000) begin n_err++; $display("FAIL midup_mole: got %h expected 000", mole); end
      n_vec++; if (score !== 8'd0) begin n_err++; $display("FAIL midup_score: got %0d expected 0", score); end
      n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL midup_state: got %0d expected 0", dbg_state); end
      rst = 1'b1;
      btn = '0;
      tick();
      n_vec++; if ({hit, busy} !== 2'b00) begin n_err++; $display("FAIL midup_after: got %b expected 00", {hit, busy}); end
   endtask

   // Test sequence and final report
   initial begin
      rst   = 1'b0;
      start = 1'b0;
      rnd   = '0;
      btn   = '0;
      test_reset();
      test_miss();
      test_hit();
      test_held_button();
      test_back_to_back();
      test_repeat();
      test_reset_mid_up();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
